// File: rtl/l2_home_responder_pkg.sv
// Shared constants, message encodings and FSM state type for the L2 home responder.
// Request encodings and response encodings occupy disjoint code ranges.
package l2_home_responder_pkg;

  localparam int unsigned AddrW        = 32;
  localparam int unsigned WordsPerLine = 4;
  localparam int unsigned WordW        = 64;
  localparam int unsigned LineW        = WordsPerLine * WordW;
  localparam int unsigned MsgW         = 5;

  localparam logic [MsgW-1:0] ReqV     = 5'd0;
  localparam logic [MsgW-1:0] ReqS     = 5'd1;
  localparam logic [MsgW-1:0] ReqO     = 5'd2;
  localparam logic [MsgW-1:0] ReqOdata = 5'd3;
  localparam logic [MsgW-1:0] ReqWt    = 5'd4;
  localparam logic [MsgW-1:0] ReqWb    = 5'd5;

  localparam logic [MsgW-1:0] RspV     = 5'd16;
  localparam logic [MsgW-1:0] RspS     = 5'd17;
  localparam logic [MsgW-1:0] RspO     = 5'd18;
  localparam logic [MsgW-1:0] RspOdata = 5'd19;
  localparam logic [MsgW-1:0] RspWt    = 5'd20;
  localparam logic [MsgW-1:0] RspWbAck = 5'd21;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StRsp
  } home_state_t;

  // Widen a per-word mask into a per-bit mask over a whole line.
  function automatic logic [LineW-1:0] expand_mask(input logic [WordsPerLine-1:0] mask);
    logic [LineW-1:0] m;
    m = '0;
    for (int i = 0; i < WordsPerLine; i++) begin
      m[i*WordW +: WordW] = {WordW{mask[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/l2_home_msg_map.sv
// Combinational request-to-response coherence message map with a supported flag.
module l2_home_msg_map
  import l2_home_responder_pkg::*;
(
  input  logic [MsgW-1:0] i_req_msg,
  output logic [MsgW-1:0] o_rsp_msg,
  output logic            o_supported
);

  always_comb begin
    o_rsp_msg   = '0;
    o_supported = 1'b1;
    case (i_req_msg)
      ReqV:     o_rsp_msg = RspV;
      ReqS:     o_rsp_msg = RspS;
      ReqO:     o_rsp_msg = RspO;
      ReqOdata: o_rsp_msg = RspOdata;
      ReqWt:    o_rsp_msg = RspWt;
      ReqWb:    o_rsp_msg = RspWbAck;
      default:  o_supported = 1'b0;
    endcase
  end

endmodule

// File: rtl/l2_home_responder.sv
// Home-side endpoint for L2 requests: services one request at a time against a
// line-granular memory port and returns a single response per supported request.
module l2_home_responder
  import l2_home_responder_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [MsgW-1:0]         i_req_coh_msg,
  input  logic                    i_req_hprot,
  input  logic [AddrW-1:0]        i_req_addr,
  input  logic [LineW-1:0]        i_req_line,
  input  logic [WordsPerLine-1:0] i_req_word_mask,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [MsgW-1:0]         o_rsp_coh_msg,
  output logic [AddrW-1:0]        o_rsp_addr,
  output logic [LineW-1:0]        o_rsp_line,
  output logic [WordsPerLine-1:0] o_rsp_word_mask,
  output logic                    o_mem_req_valid,
  input  logic                    i_mem_req_ready,
  output logic                    o_mem_req_write,
  output logic                    o_mem_req_hprot,
  output logic [AddrW-1:0]        o_mem_req_addr,
  output logic [LineW-1:0]        o_mem_req_line,
  output logic [WordsPerLine-1:0] o_mem_req_mask,
  input  logic                    i_mem_rsp_valid,
  input  logic [LineW-1:0]        i_mem_rsp_line,
  output logic                    o_bad_msg,
  output logic [15:0]             o_req_cnt
);

  home_state_t             r_state, w_state_next;
  logic [MsgW-1:0]         r_rsp_msg;
  logic                    r_hprot;
  logic [AddrW-1:0]        r_addr;
  logic [LineW-1:0]        r_line;
  logic [WordsPerLine-1:0] r_mask;
  logic [LineW-1:0]        r_rsp_line;
  logic                    r_bad_msg;
  logic [15:0]             r_cnt;

  logic [MsgW-1:0]         w_rsp_msg;
  logic                    w_supported;
  logic                    w_accept;
  logic                    w_is_write;

  l2_home_msg_map u_msg_map (
    .i_req_msg   (i_req_coh_msg),
    .o_rsp_msg   (w_rsp_msg),
    .o_supported (w_supported)
  );

  assign w_accept   = (r_state == StIdle) && i_req_valid;
  assign w_is_write = (i_req_coh_msg == ReqWt) || (i_req_coh_msg == ReqWb);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_req_valid && w_supported) begin
          if (i_req_coh_msg == ReqO) begin
            w_state_next = StRsp;
          end else if (w_is_write) begin
            w_state_next = StWrReq;
          end else begin
            w_state_next = StRdReq;
          end
        end
      end
      StRdReq:  if (i_mem_req_ready) w_state_next = StRdWait;
      StRdWait: if (i_mem_rsp_valid) w_state_next = StRsp;
      StWrReq:  if (i_mem_req_ready) w_state_next = StRsp;
      StRsp:    if (i_rsp_ready)     w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // Response data starts at zero each request so writes and REQ_O return an empty line.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_msg  <= '0;
      r_hprot    <= 1'b0;
      r_addr     <= '0;
      r_line     <= '0;
      r_mask     <= '0;
      r_rsp_line <= '0;
      r_bad_msg  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_bad_msg <= w_accept && !w_supported;
      if (w_accept) begin
        r_rsp_msg  <= w_rsp_msg;
        r_hprot    <= i_req_hprot;
        r_addr     <= i_req_addr;
        r_line     <= i_req_line;
        r_mask     <= i_req_word_mask;
        r_rsp_line <= '0;
        r_cnt      <= r_cnt + 16'd1;
      end
      if ((r_state == StRdWait) && i_mem_rsp_valid) begin
        r_rsp_line <= i_mem_rsp_line & expand_mask(r_mask);
      end
    end
  end

  always_comb begin
    o_req_ready     = 1'b0;
    o_rsp_valid     = 1'b0;
    o_rsp_coh_msg   = '0;
    o_rsp_addr      = '0;
    o_rsp_line      = '0;
    o_rsp_word_mask = '0;
    o_mem_req_valid = 1'b0;
    o_mem_req_write = 1'b0;
    o_mem_req_hprot = 1'b0;
    o_mem_req_addr  = '0;
    o_mem_req_line  = '0;
    o_mem_req_mask  = '0;
    unique case (r_state)
      StIdle: o_req_ready = 1'b1;
      StRdReq: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_hprot = r_hprot;
        o_mem_req_addr  = r_addr;
        o_mem_req_mask  = r_mask;
      end
      StWrReq: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_write = 1'b1;
        o_mem_req_hprot = r_hprot;
        o_mem_req_addr  = r_addr;
        o_mem_req_line  = r_line;
        o_mem_req_mask  = r_mask;
      end
      StRsp: begin
        o_rsp_valid     = 1'b1;
        o_rsp_coh_msg   = r_rsp_msg;
        o_rsp_addr      = r_addr;
        o_rsp_line      = r_rsp_line;
        o_rsp_word_mask = r_mask;
      end
      default: ;
    endcase
  end

  assign o_bad_msg = r_bad_msg;
  assign o_req_cnt = r_cnt;

endmodule
